// File: rtl/irr_pkg.sv
// Shared types and helpers for the irrigation scheduler: FSM state encoding,
// default sizing and the zone one-hot decode.
package irr_pkg;

  localparam int N_ZONES_DEF = 4;
  localparam int DUR_W_DEF   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IRRIGATE,
    S_PAUSE,
    S_REFILL,
    S_DONE,
    S_FAULT
  } irr_state_e;

  // Wide result; callers size-cast down to their zone count.
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    onehot = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/irr_rr_arbiter.sv
// Combinational round-robin pick: first requesting zone after 'last',
// wrapping from N_ZONES-1 back to 0.
module irr_rr_arbiter
  import irr_pkg::*;
#(
  parameter int N_ZONES = N_ZONES_DEF,
  parameter int ZW      = $clog2(N_ZONES)
) (
  input  logic [N_ZONES-1:0] req,
  input  logic [ZW-1:0]      last,
  output logic [ZW-1:0]      grant_idx,
  output logic               any
);

  int idx;

  always_comb begin
    grant_idx = '0;
    idx       = 0;
    any       = |req;
    // Scan farthest-first so the nearest requester after 'last' wins.
    for (int k = N_ZONES; k >= 1; k--) begin
      idx = (int'(last) + k) % N_ZONES;
      if (req[idx[ZW-1:0]]) begin
        grant_idx = idx[ZW-1:0];
      end
    end
  end

endmodule

// File: rtl/irrigation_scheduler.sv
// Shared-tank irrigation scheduler: round-robin zone grants, tick-timed
// watering, pause/refill on tank empty, latched sensor fault.
module irrigation_scheduler
  import irr_pkg::*;
#(
  parameter int N_ZONES = N_ZONES_DEF,
  parameter int DUR_W   = DUR_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [N_ZONES-1:0]         zone_req,
  input  logic [DUR_W-1:0]           dur,
  input  logic                       Vazio,
  input  logic                       Nivel_cheio,
  output logic [N_ZONES-1:0]         valve,
  output logic                       fill_req,
  output logic [N_ZONES-1:0]         zone_done,
  output logic [$clog2(N_ZONES)-1:0] cur_zone,
  output logic                       busy,
  output logic                       fault
);

  localparam int ZW = $clog2(N_ZONES);

  irr_state_e        state_reg, state_next;
  logic [DUR_W-1:0]  cnt_reg, cnt_next;
  logic [ZW-1:0]     cur_reg, cur_next;
  logic [ZW-1:0]     last_reg, last_next;
  logic [ZW-1:0]     grant_idx;
  logic              grant_any;

  logic [N_ZONES-1:0] valve_reg, done_reg;
  logic               fill_reg, busy_reg, fault_reg;

  irr_rr_arbiter #(.N_ZONES(N_ZONES), .ZW(ZW)) u_arb (
    .req       (zone_req),
    .last      (last_reg),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cur_next   = cur_reg;
    last_next  = last_reg;
    if (state_reg != S_FAULT && Vazio && Nivel_cheio) begin
      state_next = S_FAULT;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Vazio) begin
            state_next = S_REFILL;
          end else if (grant_any) begin
            cur_next   = grant_idx;
            cnt_next   = dur;
            state_next = (dur == '0) ? S_DONE : S_IRRIGATE;
          end
        end
        S_IRRIGATE: begin
          // A dropped request aborts silently but still advances the rotation.
          if (!zone_req[cur_reg]) begin
            last_next  = cur_reg;
            state_next = S_IDLE;
          end else if (Vazio) begin
            state_next = S_PAUSE;
          end else if (tick) begin
            cnt_next = cnt_reg - DUR_W'(1);
            if (cnt_reg == DUR_W'(1)) state_next = S_DONE;
          end
        end
        S_PAUSE: begin
          if (!zone_req[cur_reg]) begin
            last_next  = cur_reg;
            state_next = S_IDLE;
          end else if (Nivel_cheio) begin
            state_next = S_IRRIGATE;
          end
        end
        S_REFILL: begin
          if (Nivel_cheio) state_next = S_IDLE;
        end
        S_DONE: begin
          last_next  = cur_reg;
          state_next = S_IDLE;
        end
        default: state_next = S_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      cur_reg   <= '0;
      last_reg  <= ZW'(N_ZONES - 1);
      valve_reg <= '0;
      done_reg  <= '0;
      fill_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cur_reg   <= cur_next;
      last_reg  <= last_next;
      // Outputs are a registered decode of the current state, one cycle behind it.
      valve_reg <= (state_reg == S_IRRIGATE) ? N_ZONES'(onehot(32'(cur_reg))) : '0;
      done_reg  <= (state_reg == S_DONE) ? N_ZONES'(onehot(32'(cur_reg))) : '0;
      fill_reg  <= (state_reg == S_PAUSE) || (state_reg == S_REFILL);
      busy_reg  <= (state_reg != S_IDLE);
      fault_reg <= (state_reg == S_FAULT);
    end
  end

  assign valve     = valve_reg;
  assign zone_done = done_reg;
  assign fill_req  = fill_reg;
  assign busy      = busy_reg;
  assign fault     = fault_reg;
  assign cur_zone  = cur_reg;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: directed scenarios with literal expectations
// plus a randomized run compared each cycle against a behavioural model.
module tb_irrigation_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;

  localparam int M_IDLE   = 0;
  localparam int M_WATER  = 1;
  localparam int M_PAUSE  = 2;
  localparam int M_REFILL = 3;
  localparam int M_DONE   = 4;
  localparam int M_FAULT  = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [N-1:0]  zone_req;
  logic [DW-1:0] dur;
  logic          Vazio;
  logic          Nivel_cheio;
  logic [N-1:0]  valve;
  logic          fill_req;
  logic [N-1:0]  zone_done;
  logic [1:0]    cur_zone;
  logic          busy;
  logic          fault;

  always #5 clk = ~clk;

  irrigation_scheduler #(.N_ZONES(N), .DUR_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .zone_req    (zone_req),
    .dur         (dur),
    .Vazio       (Vazio),
    .Nivel_cheio (Nivel_cheio),
    .valve       (valve),
    .fill_req    (fill_req),
    .zone_done   (zone_done),
    .cur_zone    (cur_zone),
    .busy        (busy),
    .fault       (fault)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // Model: what the scheduler is doing, how many ticks remain, which zone.
  int m_mode, m_rem, m_zone, m_last;
  logic [N-1:0] e_valve, e_done;
  logic         e_fill, e_busy, e_fault;
  logic [1:0]   e_cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit found;
    if (reset) begin
      m_mode = M_IDLE; m_rem = 0; m_zone = 0; m_last = N - 1;
      e_valve = '0; e_done = '0; e_fill = 0; e_busy = 0; e_fault = 0; e_cur = '0;
      return;
    end
    // Visible outputs after this edge describe the activity before it.
    e_valve = (m_mode == M_WATER) ? N'(1 << m_zone) : '0;
    e_done  = (m_mode == M_DONE)  ? N'(1 << m_zone) : '0;
    e_fill  = (m_mode == M_PAUSE) || (m_mode == M_REFILL);
    e_busy  = (m_mode != M_IDLE);
    e_fault = (m_mode == M_FAULT);
    if (m_mode != M_FAULT && Vazio && Nivel_cheio) begin
      m_mode = M_FAULT;
    end else if (m_mode == M_IDLE) begin
      if (Vazio) m_mode = M_REFILL;
      else if (zone_req != 0) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && zone_req[(m_last + k) % N]) begin
            m_zone = (m_last + k) % N;
            found  = 1;
          end
        end
        m_rem  = int'(dur);
        m_mode = (m_rem == 0) ? M_DONE : M_WATER;
      end
    end else if (m_mode == M_WATER || m_mode == M_PAUSE) begin
      if (!zone_req[m_zone]) begin
        m_last = m_zone; m_mode = M_IDLE;
      end else if (m_mode == M_PAUSE) begin
        if (Nivel_cheio) m_mode = M_WATER;
      end else if (Vazio) begin
        m_mode = M_PAUSE;
      end else if (tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_mode = M_DONE;
      end
    end else if (m_mode == M_REFILL) begin
      if (Nivel_cheio) m_mode = M_IDLE;
    end else if (m_mode == M_DONE) begin
      m_last = m_zone; m_mode = M_IDLE;
    end
    e_cur = 2'(m_zone);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("valve", valve, e_valve);
      check("zone_done", zone_done, e_done);
      check("fill_req", fill_req, e_fill);
      check("busy", busy, e_busy);
      check("fault", fault, e_fault);
      check("cur_zone", cur_zone, e_cur);
      check("valve_onehot", $onehot0(valve), 1);
      check("valve_fill_excl", (|valve) && fill_req, 0);
    end
  end

  task automatic idle_inputs();
    tick = 0; zone_req = '0; dur = '0; Vazio = 0; Nivel_cheio = 0;
  endtask

  task automatic apply_reset();
    reset = 1; idle_inputs();
    cyc(); cyc();
    reset = 0;
  endtask

  initial begin
    int n0, n2;
    logic [N-1:0] dq[$];
    logic [N-1:0] d0, d1;

    reset = 1; idle_inputs();
    cyc();
    chk_en = 1;
    apply_reset();
    check("rst_busy", busy, 0);
    check("rst_cur_zone", cur_zone, 0);
    check("rst_valve", valve, 0);

    // Two zones share the tank; zone 0 first, then zone 2, 3 ticks each.
    zone_req = 4'b0101; dur = 8'd3; tick = 1;
    n0 = 0; n2 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (valve == 4'b0001) n0++;
      if (valve == 4'b0100) n2++;
      if (zone_done != 0) dq.push_back(zone_done);
    end
    d0 = (dq.size() > 0) ? dq[0] : 4'hF;
    d1 = (dq.size() > 1) ? dq[1] : 4'hF;
    check("rr_zone0_ticks", n0, 3);
    check("rr_zone2_ticks", n2, 3);
    check("rr_done_first", d0, 4'b0001);
    check("rr_done_second", d1, 4'b0100);

    // Zero duration: completion pulse without opening a valve.
    apply_reset();
    zone_req = 4'b1000; dur = 8'd0;
    cyc();
    check("dur0_no_pulse_yet", zone_done, 4'b0000);
    cyc();
    check("dur0_done", zone_done, 4'b1000);
    check("dur0_valve", valve, 4'b0000);

    // Both tank sensors at once while watering latches the fault.
    apply_reset();
    zone_req = 4'b0001; dur = 8'd10;
    cyc(); cyc(); cyc();
    check("pre_fault_valve", valve, 4'b0001);
    Vazio = 1; Nivel_cheio = 1;
    cyc();
    Vazio = 0; Nivel_cheio = 0;
    cyc();
    check("fault_flag", fault, 1);
    check("fault_valve", valve, 0);
    check("fault_fill", fill_req, 0);
    for (int i = 0; i < 6; i++) begin
      tick = 1'($urandom_range(0, 1)); Vazio = 1'($urandom_range(0, 1));
      Nivel_cheio = 0; zone_req = 4'($urandom);
      cyc();
    end
    check("fault_held", fault, 1);

    // Randomized run, compared to the model every cycle.
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      tick  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) zone_req = 4'($urandom);
      dur   = 8'($urandom_range(0, 5));
      Vazio = ($urandom_range(0, 15) == 0);
      Nivel_cheio = Vazio ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 5) == 0);
      cyc();
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
